mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits between the EX/MEM buffer and the MEM/WB buffer.
- Non-memory instructions pass straight through with zero latency.
- Loads and stores run a multi-cycle request/ack transaction on the data bus, with byte-lane steering, load sign/zero extension, misalignment detection and a bus timeout.
- Holds the upstream pipeline through stall_request while a transaction is in flight.

Parameters:
- BUS_TIMEOUT, 16: max BUSY cycles waiting for bus_ack before abort; range 1..255.
- TIMEOUT_WIDTH, 8: width of the timeout counter.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- ex_write_enable  input  1  instruction writes a GPR
- ex_write_addr  input  5  destination GPR (REGS_ADDR_BUS)
- ex_write_data  input  32  ALU result (REGS_DATA_BUS)
- ex_mem_op  input  4  MEM_OP_NOP/LB/LBU/LH/LHU/LW/SB/SH/SW
- ex_mem_addr  input  32  effective address
- ex_store_data  input  32  rt value for stores
- bus_request  output  1  transaction valid
- bus_write_enable  output  1  1 = store
- bus_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- bus_byte_select  output  4  active byte lanes
- bus_write_data  output  32  lane-replicated store data
- bus_read_data  input  32  read word, valid with bus_ack
- bus_ack  input  1  one-cycle completion strobe
- mem_write_enable  output  1  to MEM/WB buffer
- mem_write_addr  output  5  to MEM/WB buffer
- mem_write_data  output  32  to MEM/WB buffer
- stall_request  output  1  hold the PC, IF/ID, ID/EX and EX/MEM buffers
- exception_misaligned  output  1  one-cycle misaligned-access flag
- exception_bus_timeout  output  1  one-cycle timeout flag

Behaviour:
- Reset:
  - FSM to IDLE; counter and captured data to 0.
  - bus_request, bus_write_enable, bus_addr, bus_byte_select and bus_write_data are 0 at reset.
  - All mem_* outputs, stall_request and both exception flags are forced to 0 while reset is high.
- FSM states IDLE, BUSY, DONE.
- IDLE, ex_mem_op = NOP:
  - mem_write_* = ex_write_* combinationally; no stall.
- IDLE, aligned memory op:
  - stall_request = 1 and mem_write_enable = 0.
  - At the next edge, bus outputs are registered and the FSM moves to BUSY with counter = 0.
- Alignment rules:
  - LH/LHU/SH require addr[0] = 0.
  - LW/SW require addr[1:0] = 0.
  - Bytes are always aligned.
- Misaligned op in IDLE:
  - No bus access and no stall.
  - mem_write_enable = 0 and exception_misaligned = 1 for that cycle.
  - The FSM stays in IDLE.
- BUSY:
  - Bus outputs are held stable and stall_request = 1.
  - The counter increments each cycle.
  - On bus_ack: capture bus_read_data, drop bus_request at the edge, go to DONE.
  - If the counter reaches BUS_TIMEOUT-1 with no ack: go to IDLE, drop bus_request, pulse exception_bus_timeout for 1 cycle, and perform no GPR write.
  - bus_ack and timeout in the same cycle: ack wins.
- DONE:
  - stall_request = 0.
  - Loads: mem_write_enable = ex_write_enable, mem_write_addr = ex_write_addr, mem_write_data = formatted captured data.
  - Stores: mem_write_enable = 0.
  - Always returns to IDLE. The upstream buffer advances at this edge, so the same op is never reissued.
- Minimum load/store latency is 3 cycles (IDLE, BUSY with immediate ack, DONE).
- Byte lanes are little-endian; k = addr[1:0].
- Store steering:
  - SB: select = 4'b0001 << k, data = {4{store[7:0]}}.
  - SH: select = addr[1] ? 4'b1100 : 4'b0011, data = {2{store[15:0]}}.
  - SW: select = 4'b1111, data = store.
  - Loads: select = 4'b1111, bus_write_enable = 0.
- Load formatting:
  - LB/LBU take byte lane k.
  - LH/LHU take half lane addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - LW passes the word unchanged.
- bus_ack seen while in IDLE or DONE is ignored.
- Reset asserted mid-BUSY aborts the transaction: bus_request is 0 after the edge and no write or exception is produced.

Decomposition:
- Shared macro header (macro.v) gains:
  - MEM_OP_BUS [3:0] and the MEM_OP_* codes (NOP = 0).
  - MEM_ADDR_BUS [31:0] and BYTE_SEL_BUS [3:0].
  - The state encodings.
- One sub-module, mem_load_formatter: purely combinational lane extraction and extension (op, addr[1:0], word -> 32-bit result), reusable by the verification model.

Test Plan:
- Pass-through: NOP, ex_write_enable = 1, addr = 5'd3, data = 32'hDEADBEEF -> the same values on mem_write_* in the same cycle; stall_request = 0.
- LB sign-extension:
  - Stimulus: LB at addr 32'h0000_1003, ack in the first BUSY cycle with bus_read_data = 32'h80FF_0011.
  - Bus response: bus_addr = 32'h0000_1000, select = 4'b1111.
  - DONE response: mem_write_data = 32'hFFFF_FF80.
  - Stall: stall_request high for exactly 2 cycles.
- Store steering:
  - SH at addr 32'h0000_2002, store 32'h1234_ABCD -> select = 4'b1100, bus_write_data = 32'hABCD_ABCD, bus_write_enable = 1; no GPR write in DONE.
  - SB at addr 32'h0000_2001, store 32'h0000_00EE -> select = 4'b0010, bus_write_data = 32'hEEEE_EEEE.
- Misaligned: LW at addr 32'h0000_0006 -> exception_misaligned pulses 1 cycle, bus_request never rises, stall_request = 0.
- Timeout: LW aligned, no ack, BUS_TIMEOUT = 4 -> bus_request high 4 cycles, then exception_bus_timeout pulses and the FSM returns to IDLE.
- Timeout tie: a variant where ack arrives in the 4th BUSY cycle -> the ack completes normally and no timeout pulse is produced.
- Reset mid-BUSY: reset asserted in the 2nd BUSY cycle -> after the edge, bus_request = 0 and all mem_* = 0; a later ack is ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: bus widths, memory op codes, FSM states,
// data-bus payload and the alignment/steering helpers.
package mem_stage_pkg;

  localparam int unsigned MEM_OP_W    = 4;
  localparam int unsigned MEM_ADDR_W  = 32;
  localparam int unsigned BYTE_SEL_W  = 4;
  localparam int unsigned REGS_ADDR_W = 5;
  localparam int unsigned REGS_DATA_W = 32;

  localparam logic [MEM_OP_W-1:0] MEM_OP_NOP = 4'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LB  = 4'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LBU = 4'd2;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LH  = 4'd3;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LHU = 4'd4;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LW  = 4'd5;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SB  = 4'd6;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SH  = 4'd7;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic                   req;
    logic                   we;
    logic [MEM_ADDR_W-1:0]  addr;
    logic [BYTE_SEL_W-1:0]  sel;
    logic [REGS_DATA_W-1:0] wdata;
  } bus_req_t;

  function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
    return (op == MEM_OP_LB) || (op == MEM_OP_LBU) || (op == MEM_OP_LH) ||
           (op == MEM_OP_LHU) || (op == MEM_OP_LW);
  endfunction

  function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

  function automatic logic is_mem_op(input logic [MEM_OP_W-1:0] op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic logic is_aligned(input logic [MEM_OP_W-1:0] op, input logic [1:0] off);
    logic ok;
    ok = 1'b1;
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: ok = ~off[0];
      MEM_OP_LW, MEM_OP_SW:             ok = (off == 2'b00);
      default:                          ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Word-aligned request with little-endian lane steering and replicated store data.
  function automatic bus_req_t build_bus_req(input logic [MEM_OP_W-1:0]    op,
                                             input logic [MEM_ADDR_W-1:0]  addr,
                                             input logic [REGS_DATA_W-1:0] store);
    bus_req_t r;
    r       = '0;
    r.req   = 1'b1;
    r.we    = is_store(op);
    r.addr  = {addr[MEM_ADDR_W-1:2], 2'b00};
    r.sel   = 4'b1111;
    r.wdata = '0;
    case (op)
      MEM_OP_SB: begin
        r.sel   = 4'b0001 << addr[1:0];
        r.wdata = {4{store[7:0]}};
      end
      MEM_OP_SH: begin
        r.sel   = addr[1] ? 4'b1100 : 4'b0011;
        r.wdata = {2{store[15:0]}};
      end
      MEM_OP_SW: r.wdata = store;
      default:   r.wdata = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_load_formatter.sv
// Combinational load formatter: picks the byte/half lane from a bus word and
// sign- or zero-extends it according to the load op.
module mem_load_formatter
  import mem_stage_pkg::*;
(
  input  logic [MEM_OP_W-1:0]    op_i,
  input  logic [1:0]             offset_i,
  input  logic [REGS_DATA_W-1:0] word_i,
  output logic [REGS_DATA_W-1:0] result_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c   = word_i[{offset_i, 3'b000} +: 8];
    half_c   = offset_i[1] ? word_i[31:16] : word_i[15:0];
    result_o = word_i;
    case (op_i)
      MEM_OP_LB:  result_o = {{24{byte_c[7]}}, byte_c};
      MEM_OP_LBU: result_o = {24'b0, byte_c};
      MEM_OP_LH:  result_o = {{16{half_c[15]}}, half_c};
      MEM_OP_LHU: result_o = {16'b0, half_c};
      default:    result_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: zero-latency pass-through for ALU ops, multi-cycle
// request/ack data-bus transaction for loads and stores.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT   = 16,
  parameter int unsigned TIMEOUT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ex_write_enable,
  input  logic [REGS_ADDR_W-1:0] ex_write_addr,
  input  logic [REGS_DATA_W-1:0] ex_write_data,
  input  logic [MEM_OP_W-1:0]    ex_mem_op,
  input  logic [MEM_ADDR_W-1:0]  ex_mem_addr,
  input  logic [REGS_DATA_W-1:0] ex_store_data,
  output logic                   bus_request,
  output logic                   bus_write_enable,
  output logic [MEM_ADDR_W-1:0]  bus_addr,
  output logic [BYTE_SEL_W-1:0]  bus_byte_select,
  output logic [REGS_DATA_W-1:0] bus_write_data,
  input  logic [REGS_DATA_W-1:0] bus_read_data,
  input  logic                   bus_ack,
  output logic                   mem_write_enable,
  output logic [REGS_ADDR_W-1:0] mem_write_addr,
  output logic [REGS_DATA_W-1:0] mem_write_data,
  output logic                   stall_request,
  output logic                   exception_misaligned,
  output logic                   exception_bus_timeout
);

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(BUS_TIMEOUT - 1);

  mem_state_e                 state_q;
  logic [TIMEOUT_WIDTH-1:0]   cnt_q;
  logic [REGS_DATA_W-1:0]     rdata_q;
  logic [MEM_OP_W-1:0]        op_q;
  logic [1:0]                 off_q;
  bus_req_t                   bus_q;
  logic                       tout_q;

  logic                       aligned_c;
  logic                       issue_c;
  logic [REGS_DATA_W-1:0]     fmt_data_c;

  assign aligned_c = is_aligned(ex_mem_op, ex_mem_addr[1:0]);
  // tout_q marks the cycle after an abort; the stalled op must not be reissued then.
  assign issue_c   = (state_q == ST_IDLE) && !tout_q && is_mem_op(ex_mem_op) && aligned_c;

  mem_load_formatter u_fmt (
    .op_i     (op_q),
    .offset_i (off_q),
    .word_i   (rdata_q),
    .result_o (fmt_data_c)
  );

  // Transaction FSM with registered bus outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      op_q    <= MEM_OP_NOP;
      off_q   <= 2'b00;
      bus_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      tout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (issue_c) begin
            bus_q   <= build_bus_req(ex_mem_op, ex_mem_addr, ex_store_data);
            op_q    <= ex_mem_op;
            off_q   <= ex_mem_addr[1:0];
            cnt_q   <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q + TIMEOUT_WIDTH'(1);
          if (bus_ack) begin
            rdata_q   <= bus_read_data;
            bus_q.req <= 1'b0;
            state_q   <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            bus_q.req <= 1'b0;
            tout_q    <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_request           = bus_q.req;
  assign bus_write_enable      = bus_q.we;
  assign bus_addr              = bus_q.addr;
  assign bus_byte_select       = bus_q.sel;
  assign bus_write_data        = bus_q.wdata;
  assign exception_bus_timeout = tout_q & ~reset;

  // Writeback path and upstream stall; everything forced quiet during reset.
  always_comb begin
    mem_write_enable     = 1'b0;
    mem_write_addr       = '0;
    mem_write_data       = '0;
    stall_request        = 1'b0;
    exception_misaligned = 1'b0;
    if (!reset) begin
      mem_write_addr = ex_write_addr;
      mem_write_data = ex_write_data;
      case (state_q)
        ST_IDLE: begin
          if (!tout_q) begin
            if (!is_mem_op(ex_mem_op)) begin
              mem_write_enable = ex_write_enable;
            end else if (aligned_c) begin
              stall_request = 1'b1;
            end else begin
              exception_misaligned = 1'b1;
            end
          end
        end
        ST_BUSY: stall_request = 1'b1;
        ST_DONE: begin
          if (is_load(op_q)) begin
            mem_write_enable = ex_write_enable;
            mem_write_data   = fmt_data_c;
          end
        end
        default: stall_request = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: per-cycle expectations from a lane/extension
// model plus literal pins on the key transactions.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_write_enable;
  logic [4:0]  ex_write_addr;
  logic [31:0] ex_write_data;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic        bus_request;
  logic        bus_write_enable;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byte_select;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic        bus_ack;
  logic        mem_write_enable;
  logic [4:0]  mem_write_addr;
  logic [31:0] mem_write_data;
  logic        stall_request;
  logic        exception_misaligned;
  logic        exception_bus_timeout;

  mem_stage #(.BUS_TIMEOUT(TMO), .TIMEOUT_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .ex_write_enable(ex_write_enable), .ex_write_addr(ex_write_addr),
    .ex_write_data(ex_write_data), .ex_mem_op(ex_mem_op),
    .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .bus_request(bus_request), .bus_write_enable(bus_write_enable),
    .bus_addr(bus_addr), .bus_byte_select(bus_byte_select),
    .bus_write_data(bus_write_data), .bus_read_data(bus_read_data),
    .bus_ack(bus_ack), .mem_write_enable(mem_write_enable),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .stall_request(stall_request), .exception_misaligned(exception_misaligned),
    .exception_bus_timeout(exception_bus_timeout)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs for the current cycle
  logic        e_valid = 1'b0;
  logic        e_chk_stall, e_stall, e_mem_we, e_chk_data, e_mis, e_tout;
  logic        e_chk_bus, e_req, e_bus_we, e_chk_wdata;
  logic [4:0]  e_mem_addr;
  logic [31:0] e_mem_data, e_bus_addr, e_wdata;
  logic [3:0]  e_sel;

  // Last observed values, pinned against literals after each scenario
  int          stall_cnt = 0;
  logic [31:0] last_mem_data = '0;
  logic [31:0] last_bus_addr = '0;
  logic [31:0] last_wdata    = '0;
  logic [3:0]  last_sel      = '0;
  logic        last_bus_we   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: lane extraction by shifting, extension by value range
  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                         input logic [31:0] w);
    int unsigned k;
    logic [31:0] b, h;
    k = addr % 4;
    b = (w >> (8 * k)) & 32'hFF;
    h = (w >> (16 * (k / 2))) & 32'hFFFF;
    case (op)
      MEM_OP_LB:  return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      MEM_OP_LBU: return b;
      MEM_OP_LH:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      MEM_OP_LHU: return h;
      default:    return w;
    endcase
  endfunction

  function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] addr);
    int unsigned k;
    k = addr % 4;
    case (op)
      MEM_OP_SB: return 4'(32'd1 << k);
      MEM_OP_SH: return (k >= 2) ? 4'd12 : 4'd3;
      default:   return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] s);
    case (op)
      MEM_OP_SB: return (s & 32'hFF) * 32'h0101_0101;
      MEM_OP_SH: return (s & 32'hFFFF) * 32'h0001_0001;
      default:   return s;
    endcase
  endfunction

  // Single compare process, away from the active edge
  always @(negedge clock) begin
    if (e_valid) begin
      if (e_chk_stall) chk("stall_request", 32'(stall_request), 32'(e_stall));
      chk("mem_write_enable", 32'(mem_write_enable), 32'(e_mem_we));
      if (e_chk_data) begin
        chk("mem_write_addr", 32'(mem_write_addr), 32'(e_mem_addr));
        chk("mem_write_data", mem_write_data, e_mem_data);
      end
      chk("exception_misaligned", 32'(exception_misaligned), 32'(e_mis));
      chk("exception_bus_timeout", 32'(exception_bus_timeout), 32'(e_tout));
      if (e_chk_bus) begin
        chk("bus_request", 32'(bus_request), 32'(e_req));
        if (e_req) begin
          chk("bus_write_enable", 32'(bus_write_enable), 32'(e_bus_we));
          chk("bus_addr", bus_addr, e_bus_addr);
          chk("bus_byte_select", 32'(bus_byte_select), 32'(e_sel));
          if (e_chk_wdata) chk("bus_write_data", bus_write_data, e_wdata);
        end
      end
      if (stall_request) stall_cnt++;
      if (mem_write_enable) last_mem_data = mem_write_data;
      if (bus_request) begin
        last_bus_addr = bus_addr;
        last_sel      = bus_byte_select;
        last_wdata    = bus_write_data;
        last_bus_we   = bus_write_enable;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_clear();
    e_valid     = 1'b1;
    e_chk_stall = 1'b1;
    e_stall     = 1'b0;
    e_mem_we    = 1'b0;
    e_chk_data  = 1'b0;
    e_mem_addr  = '0;
    e_mem_data  = '0;
    e_mis       = 1'b0;
    e_tout      = 1'b0;
    e_chk_bus   = 1'b1;
    e_req       = 1'b0;
    e_bus_we    = 1'b0;
    e_bus_addr  = '0;
    e_sel       = '0;
    e_chk_wdata = 1'b0;
    e_wdata     = '0;
  endtask

  task automatic nop_cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic ack);
    ex_mem_op = MEM_OP_NOP; ex_write_enable = we; ex_write_addr = wa; ex_write_data = wd;
    ex_mem_addr = 32'h0; ex_store_data = 32'h0; bus_ack = ack; bus_read_data = 32'h1357_9BDF;
    exp_clear();
    e_mem_we = we; e_chk_data = 1'b1; e_mem_addr = wa; e_mem_data = wd;
    step();
    bus_ack = 1'b0;
  endtask

  // One load/store; ack_at = BUSY cycle carrying the ack, 0 = never
  task automatic run_mem(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] store, input logic [31:0] rdata, input int ack_at);
    logic ld, done;
    ld   = (op == MEM_OP_LB) || (op == MEM_OP_LBU) || (op == MEM_OP_LH) ||
           (op == MEM_OP_LHU) || (op == MEM_OP_LW);
    done = 1'b0;
    ex_mem_op = op; ex_mem_addr = addr; ex_store_data = store;
    ex_write_enable = ld; ex_write_addr = 5'd9; ex_write_data = 32'h5555_0000;
    bus_ack = 1'b0; bus_read_data = 32'h0;
    exp_clear(); e_stall = 1'b1;
    step();
    for (int i = 1; i <= TMO; i++) begin
      exp_clear();
      e_stall = 1'b1; e_req = 1'b1; e_bus_we = ~ld;
      e_bus_addr = addr & 32'hFFFF_FFFC; e_sel = m_sel(op, addr);
      e_chk_wdata = ~ld; e_wdata = m_wdata(op, store);
      bus_ack = (i == ack_at);
      bus_read_data = (i == ack_at) ? rdata : 32'hA5A5_A5A5;
      step();
      if (i == ack_at) begin
        done = 1'b1;
        break;
      end
    end
    bus_ack = 1'b0;
    exp_clear();
    if (done) begin
      e_mem_we = ld;
      if (ld) begin
        e_chk_data = 1'b1; e_mem_addr = 5'd9; e_mem_data = m_load(op, addr, rdata);
      end
    end else begin
      e_tout = 1'b1; e_chk_stall = 1'b0;
    end
    step();
    nop_cycle(1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; bus_ack = 1'b0; bus_read_data = '0;
    ex_mem_op = MEM_OP_NOP; ex_write_enable = 1'b1; ex_write_addr = 5'd3;
    ex_write_data = 32'hDEAD_BEEF; ex_mem_addr = '0; ex_store_data = '0;
    step();
    // Reset: everything quiet even with a live pass-through op
    exp_clear(); e_chk_data = 1'b1;
    step();
    reset = 1'b0;

    nop_cycle(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0);
    nop_cycle(1'b1, 5'd17, 32'h0BAD_F00D, 1'b1);

    stall_cnt = 0;
    run_mem(MEM_OP_LB, 32'h0000_1003, 32'h0, 32'h80FF_0011, 1);
    chk("lb_stall_cycles", 32'(stall_cnt), 32'd2);
    chk("lb_bus_addr", last_bus_addr, 32'h0000_1000);
    chk("lb_sel", 32'(last_sel), 32'h0000_000F);
    chk("lb_data", last_mem_data, 32'hFFFF_FF80);

    run_mem(MEM_OP_SH, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 2);
    chk("sh_sel", 32'(last_sel), 32'h0000_000C);
    chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(last_bus_we), 32'd1);

    run_mem(MEM_OP_SB, 32'h0000_2001, 32'h0000_00EE, 32'h0, 1);
    chk("sb_sel", 32'(last_sel), 32'h0000_0002);
    chk("sb_wdata", last_wdata, 32'hEEEE_EEEE);

    run_mem(MEM_OP_LHU, 32'h0000_2002, 32'h0, 32'h8001_1234, 3);
    chk("lhu_data", last_mem_data, 32'h0000_8001);
    run_mem(MEM_OP_LH, 32'h0000_2002, 32'h0, 32'h8001_1234, 1);
    chk("lh_data", last_mem_data, 32'hFFFF_8001);
    run_mem(MEM_OP_LBU, 32'h0000_4002, 32'h0, 32'h80FF_0011, 2);
    chk("lbu_data", last_mem_data, 32'h0000_00FF);
    run_mem(MEM_OP_LW, 32'h0000_4000, 32'h0, 32'h1234_5678, 1);
    chk("lw_data", last_mem_data, 32'h1234_5678);
    run_mem(MEM_OP_SW, 32'h0000_5000, 32'hCAFE_F00D, 32'h0, 1);
    chk("sw_wdata", last_wdata, 32'hCAFE_F00D);

    // Misaligned accesses: flag only, no bus, no stall
    foreach (ex_write_addr[i]) begin end
    ex_mem_op = MEM_OP_LW; ex_mem_addr = 32'h0000_0006; ex_write_enable = 1'b1;
    exp_clear(); e_mis = 1'b1;
    step();
    nop_cycle(1'b0, 5'd0, 32'h0, 1'b0);
    ex_mem_op = MEM_OP_LH; ex_mem_addr = 32'h0000_7001; ex_write_enable = 1'b1;
    exp_clear(); e_mis = 1'b1;
    step();
    nop_cycle(1'b0, 5'd0, 32'h0, 1'b0);

    // Timeout, then the tie where the ack lands in the last BUSY cycle
    run_mem(MEM_OP_LW, 32'h0000_3000, 32'h0, 32'h0, 0);
    run_mem(MEM_OP_LW, 32'h0000_3004, 32'h0, 32'h7777_8888, TMO);
    chk("tie_data", last_mem_data, 32'h7777_8888);

    // Reset during the second BUSY cycle, then a stray ack
    ex_mem_op = MEM_OP_LW; ex_mem_addr = 32'h0000_0100; ex_write_enable = 1'b1;
    ex_write_addr = 5'd4; ex_write_data = 32'h0;
    exp_clear(); e_stall = 1'b1;
    step();
    exp_clear(); e_stall = 1'b1; e_req = 1'b1; e_bus_addr = 32'h0000_0100; e_sel = 4'hF;
    step();
    reset = 1'b1;
    exp_clear(); e_chk_bus = 1'b0; e_chk_data = 1'b1;
    step();
    reset = 1'b0;
    nop_cycle(1'b0, 5'd0, 32'h0, 1'b1);
    nop_cycle(1'b0, 5'd0, 32'h0, 1'b0);
    nop_cycle(1'b1, 5'd7, 32'h0000_0042, 1'b0);

    e_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
